// File: rtl/lsu.sv
// RV32I load/store unit: drives a req/gnt/rvalid data-memory handshake, places store
// lanes and byte enables, and sign/zero-extends load data back to writeback.

module lsu_chk (
    input logic        clk,
    input logic        rst_n,
    input logic        mem_req_o,
    input logic        mem_gnt_i,
    input logic        done_o,
    input logic        illegal_o,
    input logic        misaligned_o,
    input logic [31:0] mem_addr_o,
    input logic [3:0]  mem_be_o
);
    a_word_addr: assert property (@(posedge clk) disable iff (!rst_n) mem_addr_o[1:0] == 2'b00);
    a_fault_excl: assert property (@(posedge clk) disable iff (!rst_n) !(illegal_o && misaligned_o));
    a_done_no_req: assert property (@(posedge clk) disable iff (!rst_n) !(done_o && mem_req_o));
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (mem_req_o && !mem_gnt_i) |=> (mem_req_o && $stable(mem_addr_o) && $stable(mem_be_o)));
endmodule

module lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    input  logic            is_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misaligned_o,
    output logic            illegal_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_r;
    logic            store_r;
    logic [2:0]      funct3_r;
    logic [1:0]      off_r;

    logic            legal_s;
    logic            misalign_s;
    logic            accept_s;
    logic [3:0]      be_s;
    logic [XLEN-1:0] lane_wdata_s;
    logic [7:0]      byte_s;
    logic [15:0]     half_s;
    logic [XLEN-1:0] load_data_s;

    // Decode funct3 legality and natural-alignment violations of the presented request
    always_comb begin
        legal_s    = 1'b0;
        misalign_s = 1'b0;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: legal_s = 1'b1;
            3'b100, 3'b101:         legal_s = ~is_store_i;
            default:                legal_s = 1'b0;
        endcase
        case (funct3_i[1:0])
            2'b01:   misalign_s = addr_i[0];
            2'b10:   misalign_s = |addr_i[1:0];
            default: misalign_s = 1'b0;
        endcase
    end

    // Fault flags, acceptance and pipeline stall
    always_comb begin
        illegal_o    = req_valid_i & ~legal_s;
        misaligned_o = req_valid_i & legal_s & misalign_s;
        accept_s     = (state_r == IDLE) & req_valid_i & legal_s & ~misalign_s;
        stall_o      = accept_s | (state_r == REQ) | (state_r == WAIT);
    end

    // Byte enables and store-lane replication for the presented access width
    always_comb begin
        be_s         = 4'b0000;
        lane_wdata_s = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_s         = 4'b0001 << addr_i[1:0];
                lane_wdata_s = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_s         = 4'b0011 << addr_i[1:0];
                lane_wdata_s = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                be_s         = 4'b1111;
                lane_wdata_s = wdata_i;
            end
            default: begin
                be_s         = 4'b0000;
                lane_wdata_s = wdata_i;
            end
        endcase
    end

    // Select the addressed lane of the returned word and extend it
    always_comb begin
        byte_s      = 8'h00;
        half_s      = 16'h0000;
        load_data_s = mem_rdata_i;
        case (off_r)
            2'b00:   byte_s = mem_rdata_i[7:0];
            2'b01:   byte_s = mem_rdata_i[15:8];
            2'b10:   byte_s = mem_rdata_i[23:16];
            2'b11:   byte_s = mem_rdata_i[31:24];
            default: byte_s = mem_rdata_i[7:0];
        endcase
        if (off_r[1]) begin
            half_s = mem_rdata_i[31:16];
        end else begin
            half_s = mem_rdata_i[15:0];
        end
        case (funct3_r)
            3'b000:  load_data_s = {{(XLEN-8){byte_s[7]}}, byte_s};
            3'b001:  load_data_s = {{(XLEN-16){half_s[15]}}, half_s};
            3'b010:  load_data_s = mem_rdata_i;
            3'b100:  load_data_s = {{(XLEN-8){1'b0}}, byte_s};
            3'b101:  load_data_s = {{(XLEN-16){1'b0}}, half_s};
            default: load_data_s = mem_rdata_i;
        endcase
    end

    // Access sequencer with registered memory-side and completion outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            store_r     <= 1'b0;
            funct3_r    <= 3'b000;
            off_r       <= 2'b00;
            done_o      <= 1'b0;
            rdata_o     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= 4'b0000;
            mem_wdata_o <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_o <= 1'b0;
                    if (accept_s) begin
                        store_r     <= is_store_i;
                        funct3_r    <= funct3_i;
                        off_r       <= addr_i[1:0];
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= is_store_i;
                        mem_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
                        mem_be_o    <= be_s;
                        mem_wdata_o <= lane_wdata_s;
                        state_r     <= REQ;
                    end
                end
                REQ: begin
                    // rvalid alongside gnt is not a legal response and is dropped here
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        done_o    <= store_r;
                        state_r   <= store_r ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        rdata_o <= load_data_s;
                        done_o  <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    done_o  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_o    <= 1'b0;
                    mem_req_o <= 1'b0;
                    mem_we_o  <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    lsu_chk u_chk (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .done_o       (done_o),
        .illegal_o    (illegal_o),
        .misaligned_o (misaligned_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o)
    );
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: vector table driven through a scripted memory responder,
// with a completion scoreboard and hand sequences for reset and stray-response cases.

module tb_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall_o, done_o, misaligned_o, illegal_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gnt_dly;
        int          rv_dly;
        logic        rv_with_gnt;
        logic [31:0] rdata;
        logic        ill;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        logic        st;
        logic [31:0] rd;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    lsu #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .is_store_i   (is_store),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .misaligned_o (misaligned_o),
        .illegal_o    (illegal_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input int gd, input int rvd,
                                input logic rvg, input logic [31:0] rdat, input logic ill,
                                input logic mis, input logic [3:0] be, input logic [31:0] ma,
                                input logic [31:0] mw, input logic [31:0] er);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.gnt_dly = gd; v.rv_dly = rvd;
        v.rv_with_gnt = rvg; v.rdata = rdat; v.ill = ill; v.mis = mis; v.be = be;
        v.maddr = ma; v.mwdata = mw; v.exp_rd = er;
        return v;
    endfunction

    // Scoreboard: every done_o pulse retires the oldest accepted access
    always @(negedge clk) begin
        if (done_o) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                sb_t r;
                r = sb_q.pop_front();
                if (!r.st) begin
                    check("load_rdata", rdata_o, r.rd);
                end
            end
        end
    end

    // Present one access and play the memory side; entry and exit just after a posedge
    task automatic run_vec(input vec_t v);
        logic fault;
        fault = v.ill | v.mis;
        req_valid = 1'b1; is_store = v.st; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        if (!fault) begin
            sb_q.push_back('{st: v.st, rd: v.exp_rd});
        end
        @(negedge clk);
        check("illegal", {31'd0, illegal_o}, {31'd0, v.ill});
        check("misaligned", {31'd0, misaligned_o}, {31'd0, v.mis});
        check("stall_accept", {31'd0, stall_o}, {31'd0, ~fault});
        if (fault) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            check("fault_no_req", {31'd0, mem_req_o}, 32'd0);
            @(posedge clk); #1;
        end else begin
            for (int k = 0; k <= v.gnt_dly; k++) begin
                @(posedge clk); #1;
                mem_gnt    = (k == v.gnt_dly);
                mem_rvalid = (k == v.gnt_dly) && v.rv_with_gnt;
                mem_rdata  = 32'hFFFF_FFFF;
                @(negedge clk);
                check("req_high", {31'd0, mem_req_o}, 32'd1);
                check("req_stall", {31'd0, stall_o}, 32'd1);
                check("req_we", {31'd0, mem_we_o}, {31'd0, v.st});
                check("req_addr", mem_addr_o, v.maddr);
                check("req_be", {28'd0, mem_be_o}, {28'd0, v.be});
                if (v.st) begin
                    check("req_wdata", mem_wdata_o, v.mwdata);
                end
            end
            @(posedge clk); #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (!v.st) begin
                for (int k = 0; k <= v.rv_dly; k++) begin
                    if (k > 0) begin
                        @(posedge clk); #1;
                    end
                    mem_rvalid = (k == v.rv_dly);
                    mem_rdata  = (k == v.rv_dly) ? v.rdata : 32'hFFFF_FFFF;
                    @(negedge clk);
                    check("wait_req_low", {31'd0, mem_req_o}, 32'd0);
                    check("wait_stall", {31'd0, stall_o}, 32'd1);
                    check("wait_no_done", {31'd0, done_o}, 32'd0);
                end
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
            end
            @(negedge clk);
            check("done_pulse", {31'd0, done_o}, 32'd1);
            check("done_no_stall", {31'd0, stall_o}, 32'd0);
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            check("done_cleared", {31'd0, done_o}, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 3'b010, 32'h1000_0008, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 4'b1111, 32'h1000_0008, 32'hDEAD_BEEF, 32'h0);
        vecs[1]  = mk(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 0, 1'b0, 32'h80FF_7F01, 1'b0, 1'b0, 4'b1000, 32'h0000_0100, 32'h0, 32'hFFFF_FF80);
        vecs[2]  = mk(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 0, 1'b0, 32'h80FF_7F01, 1'b0, 1'b0, 4'b1000, 32'h0000_0100, 32'h0, 32'h0000_0080);
        vecs[3]  = mk(1'b1, 3'b001, 32'h0000_0022, 32'h0000_ABCD, 3, 0, 1'b0, 32'h0, 1'b0, 1'b0, 4'b1100, 32'h0000_0020, 32'hABCD_ABCD, 32'h0);
        vecs[4]  = mk(1'b0, 3'b010, 32'h0000_1006, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0);
        vecs[5]  = mk(1'b0, 3'b011, 32'h0000_0006, 32'h0, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0);
        vecs[6]  = mk(1'b1, 3'b100, 32'h0000_0000, 32'h0, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0);
        vecs[7]  = mk(1'b1, 3'b001, 32'h0000_0041, 32'h1234, 0, 0, 1'b0, 32'h0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0);
        vecs[8]  = mk(1'b0, 3'b001, 32'h0000_0002, 32'h0, 0, 0, 1'b0, 32'h9876_0000, 1'b0, 1'b0, 4'b1100, 32'h0, 32'h0, 32'hFFFF_9876);
        vecs[9]  = mk(1'b0, 3'b010, 32'h0000_0004, 32'h0, 1, 2, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 4'b1111, 32'h4, 32'h0, 32'h1234_5678);
        vecs[10] = mk(1'b0, 3'b000, 32'h0000_0000, 32'h0, 0, 0, 1'b0, 32'h80FF_7F01, 1'b0, 1'b0, 4'b0001, 32'h0, 32'h0, 32'h0000_0001);
        vecs[11] = mk(1'b0, 3'b001, 32'h0000_0000, 32'h0, 0, 1, 1'b0, 32'h80FF_7F01, 1'b0, 1'b0, 4'b0011, 32'h0, 32'h0, 32'h0000_7F01);
        vecs[12] = mk(1'b1, 3'b000, 32'h0000_0002, 32'h1234_5699, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0100, 32'h0, 32'h9999_9999, 32'h0);

        // Reset with a stale response on the bus that persists past reset release
        rst_n = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_we", {31'd0, mem_we_o}, 32'd0);
        check("rst_be", {28'd0, mem_be_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("stale_rvalid_done", {31'd0, done_o}, 32'd0);
        check("stale_rvalid_rdata", rdata_o, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
        end

        // Stray rvalid while idle, then a slow LHU (rvalid 5 cycles after gnt)
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        check("stray_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("stray_no_done", {31'd0, done_o}, 32'd0);
        check("stray_no_req", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk); #1;
        run_vec(mk(1'b0, 3'b101, 32'h0000_0002, 32'h0, 0, 4, 1'b0, 32'h9876_0000, 1'b0, 1'b0, 4'b1100, 32'h0, 32'h0, 32'h0000_9876));

        // Reset while a granted load is waiting; the late rvalid must be ignored
        req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0008; wdata = 32'h0;
        sb_q.push_back('{st: 1'b0, rd: 32'h1111_1111});
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(negedge clk);
        check("rw_req", {31'd0, mem_req_o}, 32'd1);
        @(posedge clk); #1;
        mem_gnt = 1'b0; rst_n = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        check("rw_req_dropped", {31'd0, mem_req_o}, 32'd0);
        check("rw_no_done", {31'd0, done_o}, 32'd0);
        check("rw_no_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("rw_late_done", {31'd0, done_o}, 32'd0);
        check("rw_rdata_cleared", rdata_o, 32'd0);
        sb_q.delete();
        @(posedge clk); #1;
        run_vec(mk(1'b1, 3'b000, 32'h0000_0001, 32'h0000_005A, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0010, 32'h0, 32'h5A5A_5A5A, 32'h0));

        repeat (2) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit in the execute-to-memory path of the RV32I core. It consumes the ALU result as the effective address, and rs2 as store data. It runs a request/grant/response handshake to data memory, generating byte enables and lane placement. It returns sign- or zero-extended load data to writeback, and stalls the pipeline while a memory access is outstanding.

## Interface
- XLEN, 32: data/address width (riscv_pkg::XLEN); only 32 is supported.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid_i  in  1  a load/store is presented this cycle; held with the fields below until done_o.
- is_store_i  in  1  1 = store, 0 = load.
- funct3_i  in  3  RV32I width code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- addr_i  in  XLEN  effective address (ALU result).
- wdata_i  in  XLEN  store data (rs2).
- stall_o  out  1  holds upstream pipeline.
- done_o  out  1  one-cycle pulse: access complete.
- rdata_o  out  XLEN  extended load data, valid when done_o for a load.
- misaligned_o  out  1  misaligned-access exception (combinational).
- illegal_o  out  1  unsupported funct3 exception (combinational).
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  XLEN  word address; bits [1:0] are always 0.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  XLEN  lane-aligned write data.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  XLEN  read word.

## Operation
- **FSM states:** IDLE, REQ, WAIT, DONE.
- **IDLE, accepted request:** req_valid_i with legal funct3 and aligned address → capture is_store, funct3, addr[1:0], byte enables and lane data; go to REQ.
- **IDLE, faulting request:** illegal_o = req_valid_i & unsupported funct3. misaligned_o = req_valid_i & legal funct3 & misaligned. Misaligned means halfword with addr[0] = 1, or word with addr[1:0] ≠ 00. Either fault: no memory access, no state change, stall_o = 0. illegal_o has priority; misaligned_o is 0 when illegal_o is 1.
- **REQ:**
  - mem_req_o = 1; mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o stay stable until mem_gnt_i.
  - On gnt: a store goes to DONE; a load goes to WAIT.
- **WAIT:** on mem_rvalid_i, register the extended data into rdata_o and go to DONE.
- **DONE:** done_o = 1; go to IDLE. req_valid_i is ignored in DONE, because the same instruction is still presented.
- **Byte enables:**
  - byte: be = 0001 << addr[1:0], wdata = {4{wdata_i[7:0]}}.
  - half: be = 0011 << addr[1:0], wdata = {2{wdata_i[15:0]}}.
  - word: be = 1111, wdata = wdata_i.
- **Load extraction:** byte lane = mem_rdata_i[8*addr[1:0] +: 8]; half lane = mem_rdata_i[16*addr[1] +: 16]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- **Ignored responses:** mem_rvalid_i outside WAIT is ignored, including stale responses after reset. mem_gnt_i outside REQ is ignored.
- **stall_o:** = (IDLE & req_valid_i & no fault) | REQ | WAIT. It is low in DONE, so the pipeline advances on the DONE clock edge.

## Timing
- **Reset values:** after rst_n low at a clock edge:
  - state = IDLE.
  - mem_req_o = 0, mem_we_o = 0, mem_be_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - done_o = 0, rdata_o = 0.
- **Reset mid-access:** reset during REQ/WAIT drops mem_req_o on the next edge and abandons the access. No done_o is produced.
- **Memory-side outputs are registered:** mem_req_o rises the cycle after acceptance.
- **Store latency (gnt on first REQ cycle):** accept at cycle 0, REQ at 1, DONE at 2. Total 3 cycles, stall_o high in cycles 0–1.
- **Load latency:** accept at 0, REQ at 1 with gnt, rvalid at cycle ≥ 2, DONE at the cycle after rvalid. Minimum 4 cycles.
- **Backpressure and response delay:** each cycle without gnt extends REQ by one; each cycle without rvalid extends WAIT by one. Neither has an upper bound.
- **Response ordering:** rvalid in the same cycle as gnt is not legal memory behaviour and is ignored.
- **Back-to-back:** a new request is accepted in the IDLE cycle after DONE. Best case is one access per 3 cycles (store) or 4 cycles (load).

## Test plan
- **Aligned SW:** addr 0x1000_0008, wdata 0xDEAD_BEEF, gnt immediate → mem_addr 0x1000_0008, be 1111, wdata 0xDEADBEEF, done_o at cycle 2, stall_o high in cycles 0–1.
- **LB/LBU sign handling:** addr 0x0000_0103, mem_rdata 0x80FF_7F01 → LB returns 0xFFFF_FF80, LBU returns 0x0000_0080; be 1000, mem_addr 0x0000_0100.
- **SH on upper half:** addr 0x22, wdata 0x0000_ABCD, gnt delayed 3 cycles → mem_req_o held 3+1 cycles with stable be 1100, wdata 0xABCD_ABCD, mem_addr 0x20; done_o 1 cycle after gnt.
- **Faults:**
  - LW at 0x...06 → misaligned_o = 1 the same cycle, mem_req_o stays 0, stall_o = 0.
  - Load funct3 011 → illegal_o = 1, misaligned_o = 0.
- **Slow read response:** LHU at 0x02, rvalid 5 cycles after gnt with rdata 0x9876_0000 → rdata_o 0x0000_9876. stall_o stays high until DONE; a stray rvalid injected in IDLE beforehand has no effect.
- **Reset during WAIT:** load granted, rst_n low one cycle before rvalid → state IDLE, no done_o, later rvalid ignored. The next SB at 0x01 with wdata 0x5A gives be 0010, wdata 0x5A5A_5A5A.
